// File: rtl/intr_pkg.sv
// Shared constants and FSM state encoding for the interrupt controller.
package intr_pkg;

    localparam int N_INTR = 8;

    // 2'd3 is not a legal encoding; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intr_prio_onehot.sv
// Lowest-set-bit isolator: bit 0 has the highest priority, output is zero or one-hot.
module intr_prio_onehot
    import intr_pkg::*;
(
    input  logic [N_INTR-1:0] i_vec,
    output logic [N_INTR-1:0] o_onehot
);

    localparam logic [N_INTR-1:0] ONE = {{(N_INTR-1){1'b0}}, 1'b1};

    // Two's complement keeps the lowest set bit and clears every bit above it.
    assign o_onehot = i_vec & (~i_vec + ONE);

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered, masked, fixed-priority interrupt controller with req/ack/ret handshake.
// Define INTR_SYNC_EN to put a 2-flop synchronizer in front of edge detection.
module intr_ctrl
    import intr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [N_INTR-1:0] intr_in,
    input  logic              mask_we,
    input  logic [N_INTR-1:0] mask_in,
    input  logic              intr_ack,
    input  logic              intr_ret,
    output logic              intr_req,
    output logic [N_INTR-1:0] intr_selec,
    output logic [N_INTR-1:0] pending_out,
    output logic              in_service
);

    logic [N_INTR-1:0] w_lines;
    logic [N_INTR-1:0] w_rise;
    logic [N_INTR-1:0] w_clr;
    logic [N_INTR-1:0] w_cand;
    logic [N_INTR-1:0] w_sel;

    logic [N_INTR-1:0] r_prev;
    logic [N_INTR-1:0] r_pending;
    logic [N_INTR-1:0] r_mask;
    logic [N_INTR-1:0] r_selec;
    logic              r_req;
    logic              r_in_service;
    state_t            r_state;

`ifdef INTR_SYNC_EN
    logic [N_INTR-1:0] r_sync1;
    logic [N_INTR-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= intr_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lines = r_sync2;
`else
    assign w_lines = intr_in;
`endif

    assign w_rise = w_lines & ~r_prev;
    assign w_clr  = (r_state == REQ && intr_ack) ? r_selec : '0;
    assign w_cand = r_pending & r_mask;

    intr_prio_onehot u_prio (
        .i_vec    (w_cand),
        .o_onehot (w_sel)
    );

    // NOTE: every register here uses <= so all reads see the pre-edge value of the cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev       <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_selec      <= '0;
            r_req        <= 1'b0;
            r_in_service <= 1'b0;
            r_state      <= IDLE;
        end else begin
            r_prev    <= w_lines;
            // A new edge wins over the acknowledge clear on the same bit.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we)
                r_mask <= mask_in;

            case (r_state)
                IDLE: begin
                    r_req        <= 1'b0;
                    r_in_service <= 1'b0;
                    if (w_cand != '0) begin
                        r_selec <= w_sel;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end else begin
                        r_selec <= '0;
                    end
                end
                REQ: begin
                    if (intr_ack) begin
                        r_req        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (intr_ret) begin
                        r_selec      <= '0;
                        r_in_service <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_selec      <= '0;
                    r_req        <= 1'b0;
                    r_in_service <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign intr_req    = r_req;
    assign intr_selec  = r_selec;
    assign pending_out = r_pending;
    assign in_service  = r_in_service;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_intr_ctrl;
    import intr_pkg::*;

`ifdef INTR_SYNC_EN
    localparam int PD = 2;
`else
    localparam int PD = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] intr_in;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       intr_ack;
    logic       intr_ret;
    logic       intr_req;
    logic [7:0] intr_selec;
    logic [7:0] pending_out;
    logic       in_service;

    typedef struct {
        int         cyc;
        logic       req;
        logic [7:0] sel;
        logic [7:0] pend;
        logic       svc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_fail  = 0;
    bit   stim_done = 1'b0;

    intr_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .intr_in     (intr_in),
        .mask_we     (mask_we),
        .mask_in     (mask_in),
        .intr_ack    (intr_ack),
        .intr_ret    (intr_ret),
        .intr_req    (intr_req),
        .intr_selec  (intr_selec),
        .pending_out (pending_out),
        .in_service  (in_service)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got {req,sel,pend,svc}=%h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs as seen after 'off' more rising edges from now.
    task automatic expect_at(input int off, input logic req, input logic [7:0] sel,
                             input logic [7:0] pend, input logic svc, input string name);
        exp_t e;
        e.cyc = cyc + off; e.req = req; e.sel = sel; e.pend = pend; e.svc = svc; e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: compare queued expectations when their cycle arrives; flag any it missed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((intr_selec & (intr_selec - 8'd1)) != 8'd0)
                check("selec_onehot", {10'd0, intr_selec}, 18'd0);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc)
                    check({e.name, "_missed"}, 18'(cyc), 18'(e.cyc));
                else
                    check(e.name, {intr_req, intr_selec, pending_out, in_service},
                                  {e.req, e.sel, e.pend, e.svc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; intr_in = '0; mask_we = 1'b0; mask_in = '0; intr_ack = 1'b0; intr_ret = 1'b0;
        tick();
        expect_at(0, 0, 8'h00, 8'h00, 0, "reset_state");
        tick();
        reset = 1'b0;
        mask_we = 1'b1; mask_in = 8'hFF; tick(); mask_we = 1'b0;

        // T1: single line 3
        intr_in = 8'h08;
        expect_at(1 + PD, 0, 8'h00, 8'h08, 0, "t1_pend");
        expect_at(2 + PD, 1, 8'h08, 8'h08, 0, "t1_req");
        tick(); intr_in = 8'h00;
        repeat (1 + PD) tick();
        intr_ack = 1'b1; expect_at(1, 0, 8'h08, 8'h00, 1, "t1_ack"); tick(); intr_ack = 1'b0;
        intr_ret = 1'b1; expect_at(1, 0, 8'h00, 8'h00, 0, "t1_ret"); tick(); intr_ret = 1'b0;

        // T2: lines 5 and 1 together; 1 wins, 5 follows after one IDLE cycle
        intr_in = 8'h22;
        expect_at(1 + PD, 0, 8'h00, 8'h22, 0, "t2_pend");
        expect_at(2 + PD, 1, 8'h02, 8'h22, 0, "t2_req_first");
        repeat (2 + PD) tick();
        intr_in = 8'h00;
        intr_ack = 1'b1; expect_at(1, 0, 8'h02, 8'h20, 1, "t2_ack"); tick(); intr_ack = 1'b0;
        intr_ret = 1'b1;
        expect_at(1, 0, 8'h00, 8'h20, 0, "t2_idle_gap");
        expect_at(2, 1, 8'h20, 8'h20, 0, "t2_req_second");
        tick(); intr_ret = 1'b0; tick();
        intr_ack = 1'b1; intr_ret = 1'b1;
        expect_at(1, 0, 8'h20, 8'h00, 1, "t2_ack_with_ret");
        tick(); intr_ack = 1'b0; intr_ret = 1'b0;
        expect_at(1, 0, 8'h20, 8'h00, 1, "t2_ret_dropped"); tick();
        intr_ret = 1'b1; expect_at(1, 0, 8'h00, 8'h00, 0, "t2_ret"); tick(); intr_ret = 1'b0;

        // T3: masked line stays pending, then unmask
        mask_we = 1'b1; mask_in = 8'h00; tick(); mask_we = 1'b0;
        intr_in = 8'h04;
        expect_at(1 + PD, 0, 8'h00, 8'h04, 0, "t3_pend_masked");
        expect_at(3 + PD, 0, 8'h00, 8'h04, 0, "t3_masked_no_req");
        repeat (3 + PD) tick();
        intr_in = 8'h00;
        mask_we = 1'b1; mask_in = 8'h04;
        expect_at(1, 0, 8'h00, 8'h04, 0, "t3_mask_write");
        expect_at(2, 1, 8'h04, 8'h04, 0, "t3_unmask_req");
        tick(); mask_we = 1'b0; tick();
        intr_ack = 1'b1; expect_at(1, 0, 8'h04, 8'h00, 1, "t3_ack"); tick(); intr_ack = 1'b0;
        intr_ret = 1'b1; expect_at(1, 0, 8'h00, 8'h00, 0, "t3_ret"); tick(); intr_ret = 1'b0;

        // T4: frozen selection and set-wins-over-clear
        mask_we = 1'b1; mask_in = 8'hFF; tick(); mask_we = 1'b0;
        intr_in = 8'h10;
        expect_at(2 + PD, 1, 8'h10, 8'h10, 0, "t4_req");
        tick(); intr_in = 8'h00;
        repeat (1 + PD) tick();
        intr_in = 8'h01;
        expect_at(1 + PD, 1, 8'h10, 8'h11, 0, "t4_selec_frozen");
        repeat (1 + PD) tick();
        intr_in = 8'h11; intr_ack = 1'b1;
        expect_at(1, 0, 8'h10, (PD == 0) ? 8'h11 : 8'h01, 1, "t4_ack_set_wins");
        tick(); intr_ack = 1'b0; intr_in = 8'h00;
        intr_ret = 1'b1;
        expect_at(1, 0, 8'h00, 8'h11, 0, "t4_ret");
        expect_at(2, 1, 8'h01, 8'h11, 0, "t4_next_req");
        tick(); intr_ret = 1'b0; tick();
        intr_ack = 1'b1; expect_at(1, 0, 8'h01, 8'h10, 1, "t4_ack2"); tick(); intr_ack = 1'b0;

        // T5: reset during SERVICE with pending 8'h81
        intr_ret = 1'b1; expect_at(1, 0, 8'h00, 8'h10, 0, "t5_ret"); tick(); intr_ret = 1'b0;
        expect_at(1, 1, 8'h10, 8'h10, 0, "t5_req"); tick();
        intr_ack = 1'b1; expect_at(1, 0, 8'h10, 8'h00, 1, "t5_ack"); tick(); intr_ack = 1'b0;
        intr_in = 8'h81;
        expect_at(1 + PD, 0, 8'h10, 8'h81, 1, "t5_pend81");
        repeat (1 + PD) tick();
        reset = 1'b1;
        expect_at(1, 0, 8'h00, 8'h00, 0, "t5_reset_clears");
        tick(); reset = 1'b0;
        // Lines still high after reset count as edges; mask is back to 0 so no request.
        expect_at(1 + PD, 0, 8'h00, 8'h81, 0, "t5_edge_after_reset");
        expect_at(3 + PD, 0, 8'h00, 8'h81, 0, "t5_mask_cleared");
        repeat (3 + PD) tick();

        // T6: line 7 held high for 3 cycles
        reset = 1'b1; intr_in = 8'h00; tick(); reset = 1'b0;
        mask_we = 1'b1; mask_in = 8'hFF; tick(); mask_we = 1'b0;
        intr_in = 8'h80;
        expect_at(1 + PD, 0, 8'h00, 8'h80, 0, "t6_pend");
        expect_at(2 + PD, 1, 8'h80, 8'h80, 0, "t6_req80");
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) intr_in = 8'h00;
        end

        repeat (3) tick();
        if (exp_q.size() != 0)
            check("scoreboard_drained", 18'(exp_q.size()), 18'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
